// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, constants and write-port arbitration for the register file
package regfile_pkg;

  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int MAX_WR     = 8;
  localparam int MAX_AW     = 8;
  localparam int PORT_W     = $clog2(MAX_WR);

  typedef logic [REG_DATA_W-1:0] reg_data_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

  typedef struct packed {
    logic              hit;
    logic [PORT_W-1:0] port;
  } wr_pick_t;

  // Later ports overwrite earlier matches, so the highest-index enabled port wins.
  function automatic wr_pick_t pick_wr_port(input logic [MAX_WR-1:0]             en,
                                            input logic [MAX_WR-1:0][MAX_AW-1:0] addr,
                                            input logic [MAX_AW-1:0]             a);
    wr_pick_t p;
    p = '0;
    for (int j = 0; j < MAX_WR; j++) begin
      if (en[j] && addr[j] == a) begin
        p.hit  = 1'b1;
        p.port = PORT_W'(j);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending bits for RAW hazard detection
// An issue to a register takes precedence over a retiring write to it in the same cycle.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_WR     = 2,
  parameter int CNT_W      = $clog2(NUM_REGS + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         iss_valid_i,
  input  logic [ADDR_WIDTH-1:0]        iss_rd_i,
  input  logic [NUM_WR-1:0]            clr_en_i,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] clr_addr_i,
  output logic [NUM_REGS-1:0]          pending_o,
  output logic [CNT_W-1:0]             pend_cnt_o
);

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_comb begin
    pend_d = pend_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (clr_en_i[j]) pend_d[clr_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
    end
    if (iss_valid_i) pend_d[iss_rd_i] = 1'b1;
    pend_d[0] = 1'b0;
    cnt_d = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d = cnt_d + CNT_W'(pend_d[r]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pending_o  = pend_q;
  assign pend_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_mp_bypass.sv
// rtl/regfile_mp_bypass.sv - multi-port register file with optional write-to-read bypass
// x0 reads as zero; the scoreboard tracks registers awaiting a producer.
module regfile_mp_bypass
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_W,
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int NUM_REGS   = 1 << ADDR_WIDTH,
  parameter int NUM_RD     = 3,
  parameter int NUM_WR     = 2,
  parameter int BYPASS     = 1,
  parameter int CNT_W      = $clog2(NUM_REGS + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data_o,
  output logic [NUM_RD-1:0]            rd_busy_o,
  input  logic [NUM_WR-1:0]            wr_en_i,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data_i,
  input  logic [NUM_WR-1:0]            wr_clr_i,
  input  logic                         iss_valid_i,
  input  logic [ADDR_WIDTH-1:0]        iss_rd_i,
  output logic [CNT_W-1:0]             pend_cnt_o
);

  logic [DATA_WIDTH-1:0]          regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]          regs_d [NUM_REGS];
  logic [MAX_WR-1:0]              wen_pad;
  logic [MAX_WR-1:0]              clr_pad;
  logic [MAX_WR-1:0][MAX_AW-1:0]  waddr_pad;
  logic [NUM_REGS-1:0]            pending;
  logic [NUM_WR-1:0]              clr_en;
  wr_pick_t                       st_pick;

  function automatic logic [DATA_WIDTH-1:0] sel_wr_data(input logic [NUM_WR*DATA_WIDTH-1:0] wd,
                                                        input logic [PORT_W-1:0]            port);
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (port == PORT_W'(j)) d = wd[j*DATA_WIDTH +: DATA_WIDTH];
    end
    return d;
  endfunction

  // Widen the write ports to the fixed shape the shared arbitration function expects.
  always_comb begin
    wen_pad   = '0;
    clr_pad   = '0;
    waddr_pad = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wen_pad[j]   = wr_en_i[j];
      clr_pad[j]   = wr_en_i[j] && wr_clr_i[j];
      waddr_pad[j] = MAX_AW'(wr_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH]);
    end
  end

  always_comb begin
    regs_d  = regs_q;
    st_pick = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      st_pick = pick_wr_port(wen_pad, waddr_pad, MAX_AW'(r));
      if (st_pick.hit) regs_d[r] = sel_wr_data(wr_data_i, st_pick.port);
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) regs_q <= '{default: '0};
    else         regs_q <= regs_d;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] data;
    logic                  busy;
    logic                  clr_hit;
    wr_pick_t              pick;

    assign a = rd_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];

    // Forwarding is suppressed during reset so in-flight writes never leak out.
    always_comb begin
      pick    = pick_wr_port(wen_pad, waddr_pad, MAX_AW'(a));
      clr_hit = 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (clr_pad[j] && waddr_pad[j] == MAX_AW'(a)) clr_hit = 1'b1;
      end
      data = regs_q[a];
      if (BYPASS != 0 && pick.hit && rst_ni) data = sel_wr_data(wr_data_i, pick.port);
      busy = pending[a] && !(BYPASS != 0 && clr_hit);
      if (a == '0) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign rd_data_o[i*DATA_WIDTH +: DATA_WIDTH] = data;
    assign rd_busy_o[i]                          = busy;
  end

  assign clr_en = wr_en_i & wr_clr_i;

  regfile_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_WR    (NUM_WR),
    .CNT_W     (CNT_W)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .iss_valid_i(iss_valid_i),
    .iss_rd_i   (iss_rd_i),
    .clr_en_i   (clr_en),
    .clr_addr_i (wr_addr_i),
    .pending_o  (pending),
    .pend_cnt_o (pend_cnt_o)
  );

endmodule

// File: tb/tb_regfile_mp_bypass.sv
// tb/tb_regfile_mp_bypass.sv - scoreboard bench for bypassing and non-bypassing register files
module tb_regfile_mp_bypass;
  import regfile_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;
  localparam int NW = 2;
  localparam int CW = 6;

  localparam int K_BD = 0, K_BB = 1, K_BC = 2, K_ND = 3, K_NB = 4, K_NC = 5;

  logic             clk;
  logic             rst_n;
  logic [NR*AW-1:0] rd_addr;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic [NW-1:0]    wr_clr;
  logic             iss_valid;
  logic [AW-1:0]    iss_rd;

  logic [NR*DW-1:0] rd_data_b, rd_data_n;
  logic [NR-1:0]    rd_busy_b, rd_busy_n;
  logic [CW-1:0]    pend_cnt_b, pend_cnt_n;

  typedef struct {
    string       name;
    int          kind;
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  regfile_mp_bypass #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b), .rd_busy_o(rd_busy_b),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_clr_i(wr_clr),
    .iss_valid_i(iss_valid), .iss_rd_i(iss_rd), .pend_cnt_o(pend_cnt_b)
  );

  regfile_mp_bypass #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0)) dut_n (
    .clk_i(clk), .rst_ni(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_n), .rd_busy_o(rd_busy_n),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_clr_i(wr_clr),
    .iss_valid_i(iss_valid), .iss_rd_i(iss_rd), .pend_cnt_o(pend_cnt_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #20000;
    if (!done) begin
      errors++;
      $display("FAIL timeout: stimulus did not complete within the wait limit");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] got;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        K_BD:    got = rd_data_b[e.port*DW +: DW];
        K_BB:    got = 32'(rd_busy_b[e.port]);
        K_BC:    got = 32'(pend_cnt_b);
        K_ND:    got = rd_data_n[e.port*DW +: DW];
        K_NB:    got = 32'(rd_busy_n[e.port]);
        default: got = 32'(pend_cnt_n);
      endcase
      checks++;
      if (got !== e.val) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, got, e.val);
      end
    end
  end

  function automatic void push(input string name, input int kind, input int port, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.port = port;
    e.val  = val;
    sb_q.push_back(e);
  endfunction

  task automatic check_reset_state(input string name);
    checks++;
    if (rd_data_b !== '0 || rd_data_n !== '0 || rd_busy_b !== '0 || rd_busy_n !== '0 ||
        pend_cnt_b !== '0 || pend_cnt_n !== '0) begin
      errors++;
      $display("FAIL %s: data_b %h data_n %h busy_b %b busy_n %b cnt_b %0d cnt_n %0d", name,
               rd_data_b, rd_data_n, rd_busy_b, rd_busy_n, pend_cnt_b, pend_cnt_n);
    end
  endtask

  task automatic drive_idle();
    wr_en     = '0;
    wr_clr    = '0;
    wr_addr   = '0;
    wr_data   = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
  endtask

  task automatic set_wr(input int p, input reg_addr_t a, input reg_data_t d, input logic clr);
    wr_en[p]            = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*DW +: DW] = d;
    wr_clr[p]           = clr;
  endtask

  task automatic set_rd(input int p, input reg_addr_t a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic issue(input reg_addr_t a);
    iss_valid = 1'b1;
    iss_rd    = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    rd_addr = '0;
    drive_idle();
    @(posedge clk);
    #1;
    check_reset_state("rst_direct");
    for (int p = 0; p < NR; p++) begin
      push("rst_data", K_BD, p, 32'h0);
      push("rst_busy", K_BB, p, 32'h0);
    end
    push("rst_cnt", K_BC, 0, 32'h0);
    push("rst_cnt_nb", K_NC, 0, 32'h0);
    tick();
    rst_n = 1'b1;

    set_wr(0, 5'd5, 32'hDEADBEEF, 1'b0); issue(5'd5);
    set_rd(0, 5'd5); set_rd(1, 5'd5); set_rd(2, 5'd5);
    push("x5_bypass", K_BD, 0, 32'hDEADBEEF);
    push("x5_nb_old", K_ND, 0, 32'h0);
    push("x5_busy_noiss", K_BB, 0, 32'h0);
    tick();
    drive_idle();
    push("x5_stored", K_BD, 0, 32'hDEADBEEF);
    push("x5_nb_stored", K_ND, 1, 32'hDEADBEEF);
    push("x5_busy", K_BB, 0, 32'h1);
    push("x5_busy_nb", K_NB, 2, 32'h1);
    push("x5_cnt", K_BC, 0, 32'h1);
    tick();

    set_wr(0, 5'd6, 32'h00000077, 1'b0); issue(5'd6);
    set_rd(1, 5'd6); set_rd(2, 5'd6);
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst_direct");
    push("midrst_x5", K_BD, 0, 32'h0);
    push("midrst_x6_byp", K_BD, 1, 32'h0);
    push("midrst_x6_nb", K_ND, 1, 32'h0);
    push("midrst_busy", K_BB, 0, 32'h0);
    push("midrst_cnt", K_BC, 0, 32'h0);
    push("midrst_cnt_nb", K_NC, 0, 32'h0);
    tick();
    drive_idle();
    rst_n = 1'b1;
    push("postrst_x6", K_BD, 1, 32'h0);
    push("postrst_x6_nb", K_ND, 1, 32'h0);
    push("postrst_x5", K_BD, 0, 32'h0);
    push("postrst_busy", K_BB, 1, 32'h0);
    push("postrst_cnt", K_BC, 0, 32'h0);
    tick();

    set_wr(0, REG_ZERO, 32'h00001234, 1'b0); issue(REG_ZERO);
    set_rd(0, REG_ZERO);
    push("x0_byp", K_BD, 0, 32'h0);
    push("x0_nb", K_ND, 0, 32'h0);
    push("x0_busy", K_BB, 0, 32'h0);
    tick();
    drive_idle();
    push("x0_after", K_BD, 0, 32'h0);
    push("x0_after_nb", K_ND, 0, 32'h0);
    push("x0_cnt", K_BC, 0, 32'h0);
    push("x0_cnt_nb", K_NC, 0, 32'h0);
    tick();

    set_wr(0, 5'd7, 32'hA5A5A5A5, 1'b0);
    set_rd(0, 5'd7);
    push("x7_bypass", K_BD, 0, 32'hA5A5A5A5);
    push("x7_nb_old", K_ND, 0, 32'h0);
    tick();
    drive_idle();
    push("x7_stored", K_BD, 0, 32'hA5A5A5A5);
    push("x7_nb_next", K_ND, 0, 32'hA5A5A5A5);
    tick();

    set_wr(0, 5'd3, 32'h11, 1'b0); set_wr(1, 5'd3, 32'h22, 1'b0);
    set_rd(0, 5'd3); set_rd(1, 5'd3);
    push("coll_byp0", K_BD, 0, 32'h22);
    push("coll_byp1", K_BD, 1, 32'h22);
    push("coll_nb_old", K_ND, 0, 32'h0);
    tick();
    drive_idle();
    push("coll_stored", K_BD, 0, 32'h22);
    push("coll_nb_stored", K_ND, 0, 32'h22);
    tick();

    set_wr(0, 5'd3, 32'h44, 1'b0); set_wr(1, 5'd8, 32'h55, 1'b0);
    set_rd(1, 5'd8);
    push("split_x3", K_BD, 0, 32'h44);
    push("split_x8", K_BD, 1, 32'h55);
    push("split_x3_nb", K_ND, 0, 32'h22);
    push("split_x8_nb", K_ND, 1, 32'h0);
    tick();
    drive_idle();
    push("split_x3_nb2", K_ND, 0, 32'h44);
    push("split_x8_nb2", K_ND, 1, 32'h55);
    tick();

    issue(5'd9);
    set_rd(2, 5'd9);
    push("iss9_busy0", K_BB, 2, 32'h0);
    push("iss9_cnt0", K_BC, 0, 32'h0);
    tick();
    drive_idle();
    push("iss9_busy", K_BB, 2, 32'h1);
    push("iss9_busy_nb", K_NB, 2, 32'h1);
    push("iss9_cnt", K_BC, 0, 32'h1);
    push("iss9_cnt_nb", K_NC, 0, 32'h1);
    tick();
    set_wr(1, 5'd9, 32'h99, 1'b1);
    push("clr9_busy_byp", K_BB, 2, 32'h0);
    push("clr9_busy_nb", K_NB, 2, 32'h1);
    push("clr9_data_byp", K_BD, 2, 32'h99);
    push("clr9_data_nb", K_ND, 2, 32'h0);
    push("clr9_cnt_reg", K_BC, 0, 32'h1);
    tick();
    drive_idle();
    push("clr9_busy_after", K_BB, 2, 32'h0);
    push("clr9_busy_nb_after", K_NB, 2, 32'h0);
    push("clr9_cnt", K_BC, 0, 32'h0);
    push("clr9_cnt_nb", K_NC, 0, 32'h0);
    push("clr9_data_nb_after", K_ND, 2, 32'h99);
    tick();

    issue(5'd10);
    set_rd(0, 5'd10);
    tick();
    drive_idle();
    wr_clr[0]       = 1'b1;
    wr_addr[0 +: AW] = 5'd10;
    push("clr_noen_busy", K_BB, 0, 32'h1);
    push("clr_noen_cnt0", K_BC, 0, 32'h1);
    tick();
    drive_idle();
    push("clr_noen_busy2", K_BB, 0, 32'h1);
    push("clr_noen_cnt", K_BC, 0, 32'h1);
    push("clr_noen_cnt_nb", K_NC, 0, 32'h1);
    tick();

    issue(5'd4);
    set_rd(1, 5'd4);
    tick();
    drive_idle();
    push("iss4_busy", K_BB, 1, 32'h1);
    push("iss4_cnt", K_BC, 0, 32'h2);
    tick();
    issue(5'd4);
    set_wr(0, 5'd4, 32'h4444, 1'b1); set_wr(1, 5'd11, 32'hBB, 1'b1);
    push("sbc_busy_byp", K_BB, 1, 32'h0);
    push("sbc_busy_nb", K_NB, 1, 32'h1);
    push("sbc_data_byp", K_BD, 1, 32'h4444);
    tick();
    drive_idle();
    push("sbc_busy_after", K_BB, 1, 32'h1);
    push("sbc_busy_nb_after", K_NB, 1, 32'h1);
    push("sbc_cnt", K_BC, 0, 32'h2);
    push("sbc_cnt_nb", K_NC, 0, 32'h2);
    push("sbc_data_nb", K_ND, 1, 32'h4444);
    tick();

    set_wr(0, 5'd10, 32'h0, 1'b1); set_wr(1, 5'd4, 32'h40, 1'b1);
    push("dual_clr_cnt_reg", K_BC, 0, 32'h2);
    tick();
    drive_idle();
    push("dual_clr_cnt", K_BC, 0, 32'h0);
    push("dual_clr_cnt_nb", K_NC, 0, 32'h0);
    push("dual_clr_busy0", K_BB, 0, 32'h0);
    push("dual_clr_busy1", K_BB, 1, 32'h0);
    push("dual_clr_x4", K_BD, 1, 32'h40);
    tick();

    @(negedge clk);
    #1;
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
